seg7_update_sequencer: RTL
==========================

// Module: seg7_update_sequencer
// PURPOSE
//  Bus-master sequencer that shares the 7-segment display peripheral between two position sources.
//  Picks one requester (round-robin) and latches its X/Y bytes, then requests the shared 8-bit bus.
//  Once granted, it writes X to SEG7_BASE and Y to SEG7_BASE+1, acknowledges the requester and enforces a hold-off.
//  Sits between the position sources (e.g. mouse, IR) and the system bus arbiter.
// PARAMETERS
//  SEG7_BASE      8'hD0  bus address of display X register; Y register is at SEG7_BASE+1
//  HOLDOFF_CYCLES 16     idle cycles after each completed update (0 = no hold-off); counter is 16 bits
//  GNT_TIMEOUT    255    cycles to wait for BUS_GNT before aborting (1..255); counter is 8 bits
// PORTS
//  CLK          in    1  system clock, all logic on rising edge
//  RESET        in    1  asynchronous, active-low reset
//  REQ0         in    1  requester 0 update request, level, held until ACK0
//  X0, Y0       in    8  requester 0 position bytes
//  REQ1         in    1  requester 1 update request, level, held until ACK1
//  X1, Y1       in    8  requester 1 position bytes
//  ACK0, ACK1   out   1  one-cycle pulse: update of that requester completed
//  BUS_REQ      out   1  request to system bus arbiter
//  BUS_GNT      in    1  grant from system bus arbiter
//  BUS_ADDR     out   8  bus address, driven to SEG7_BASE/SEG7_BASE+1 only in WRX/WRY
//  BUS_DATA     inout 8  bus data; driven only in WRX/WRY, high-Z otherwise
//  BUS_WE       out   1  bus write enable
//  BUSY         out   1  high in every state except IDLE
//  TIMEOUT_ERR  out   1  sticky: a grant wait timed out
//  CLR_ERR      in    1  synchronous clear of TIMEOUT_ERR
// BEHAVIOUR
//  Reset (RESET=0, async):
//   - state=IDLE, BUS_REQ=0, BUS_WE=0, BUS_ADDR=8'h00, BUS_DATA=Z
//   - ACK0=ACK1=0, BUSY=0, TIMEOUT_ERR=0, round-robin pointer=0 (requester 1 has priority next)
//   - latched X/Y=0, all counters=0
//   - reset mid-transfer: bus is released at once; no ACK is issued
//  FSM: IDLE -> WAIT_GNT -> WRX -> WRY -> ACK -> HOLD -> IDLE
//   IDLE:
//    - if either REQ is high, choose a winner, latch its X/Y, store its id, go to WAIT_GNT
//    - only one REQ high: that requester wins
//    - both high: the requester not served last wins; the pointer updates when the winner is chosen
//   WAIT_GNT:
//    - BUS_REQ=1, wait counter increments each cycle
//    - BUS_GNT=1 sampled -> WRX
//    - counter reaches GNT_TIMEOUT with no grant -> IDLE; set TIMEOUT_ERR; no ACK; pointer still advances
//   WRX: BUS_REQ=1, BUS_WE=1, BUS_ADDR=SEG7_BASE, BUS_DATA=latched X (one cycle)
//   WRY: BUS_REQ=1, BUS_WE=1, BUS_ADDR=SEG7_BASE+1 (8-bit wrap), BUS_DATA=latched Y (one cycle)
//   ACK: BUS_REQ=0, BUS_WE=0; ACKn=1 for the stored id (one cycle)
//   HOLD: stay HOLDOFF_CYCLES cycles, then IDLE; with HOLDOFF_CYCLES=0, ACK goes directly to IDLE
//  Grant rules:
//   - bus arbitration is non-preemptive: BUS_GNT is ignored after WAIT_GNT
//   - WRX/WRY always complete once entered
//  Latency:
//   - REQ sampled in IDLE at edge n with BUS_GNT already high: WRX at n+2, WRY at n+3, ACK pulse at n+4
//  Data and request changes:
//   - X/Y changes after latching do not affect the write in progress
//   - REQ dropped before ACK: the transfer still completes and ACK is still pulsed
//   - a requester still high after its ACK is re-arbitrated after HOLD
//  TIMEOUT_ERR:
//   - set on a timeout event, cleared by CLR_ERR
//   - timeout and CLR_ERR in the same cycle: set wins
//  BUSY: 1 in WAIT_GNT, WRX, WRY, ACK and HOLD
// TESTING
//  T1: REQ0=1, X0=8'h12, Y0=8'h34, BUS_GNT=1 -> writes D0<=12 at n+2 and D1<=34 at n+3, ACK0 pulse at n+4, BUS_DATA Z outside WRX/WRY
//  T2: REQ0 and REQ1 held high together -> serviced alternately 1,0,1,0; ACK pulses alternate; HOLD of 16 cycles between updates
//  T3: BUS_GNT held low -> BUS_REQ high for 255 cycles, then TIMEOUT_ERR=1, no ACK, no write; CLR_ERR pulse -> TIMEOUT_ERR=0
//  T4: X0 changed to 8'hFF during WAIT_GNT -> the write still carries the originally latched X
//  T5: RESET low during WRX -> BUS_WE=0, BUS_REQ=0, BUS_DATA=Z immediately, no ACK; after release, REQ0 is serviced normally
//  T6: SEG7_BASE=8'hFF -> the Y write goes to address 8'h00 (wrap)

Source files
------------

// File: rtl/seg7_update_sequencer.sv
// Round-robin bus-master sequencer: latches one source's X/Y position and writes it
// to the shared 7-segment display registers over the 8-bit system bus.
module seg7_update_sequencer #(
    parameter logic [7:0]  SEG7_BASE      = 8'hD0,
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned GNT_TIMEOUT    = 255
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic [7:0] X0,
    input  logic [7:0] Y0,
    input  logic       REQ1,
    input  logic [7:0] X1,
    input  logic [7:0] Y1,
    output logic       ACK0,
    output logic       ACK1,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    output logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic       BUSY,
    output logic       TIMEOUT_ERR,
    input  logic       CLR_ERR
);

    localparam logic [7:0]  ADDR_Y    = SEG7_BASE + 8'h01;
    localparam logic [7:0]  GNT_LAST  = 8'(GNT_TIMEOUT - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT,
        WRX,
        WRY,
        ACK,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic        err_q, err_d;
    logic        win;
    logic        set_err;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            wcnt_q  <= '0;
            hcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        wcnt_d  = '0;
        hcnt_d  = '0;
        set_err = 1'b0;
        // ptr_q holds the last winner; on contention the other requester goes next
        win     = (REQ0 && REQ1) ? ~ptr_q : REQ1;

        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    id_d    = win;
                    ptr_d   = win;
                    x_d     = win ? X1 : X0;
                    y_d     = win ? Y1 : Y0;
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (BUS_GNT) begin
                    state_d = WRX;
                end else if (wcnt_q == GNT_LAST) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            WRX: state_d = WRY;
            WRY: state_d = ACK;
            ACK: state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
            HOLD: begin
                if (hcnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = set_err ? 1'b1 : (CLR_ERR ? 1'b0 : err_q);
    end

    logic       drive;
    logic [7:0] data_out;

    always_comb begin
        drive    = (state_q == WRX) || (state_q == WRY);
        BUS_REQ  = (state_q == WAIT_GNT) || drive;
        BUS_WE   = drive;
        BUS_ADDR = '0;
        data_out = '0;
        if (state_q == WRX) begin
            BUS_ADDR = SEG7_BASE;
            data_out = x_q;
        end else if (state_q == WRY) begin
            BUS_ADDR = ADDR_Y;
            data_out = y_q;
        end
        ACK0        = (state_q == ACK) && !id_q;
        ACK1        = (state_q == ACK) && id_q;
        BUSY        = (state_q != IDLE);
        TIMEOUT_ERR = err_q;
    end

    assign BUS_DATA = drive ? data_out : 8'hzz;

endmodule
